clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised successor to the team's fixed-ratio divider: NUM_CH independent programmable dividers driven from the single board clock.
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe.
- Divisors are reloaded at run time through a valid/ready port and take effect glitch-free at the next wrap.
- Feeds LED/display sequencing logic that needs several slow rates.

Parameters:
- CNT_W, 27, width of each channel counter and divisor.
- NUM_CH, 4, number of channels (1..16).
- CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_CH.
- DEFAULT_DIV, 2500000, divisor loaded into every channel at reset.

Ports:
- clki  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  NUM_CH  per-channel run enable.
- load_valid  in  1  divisor load request.
- load_ch  in  CH_W  target channel of the load.
- load_div  in  CNT_W  new divisor value.
- load_ready  out  1  load accepted when load_valid and load_ready are both high at a clki edge.
- tick  out  NUM_CH  one-cycle pulse per channel at each counter wrap.
- clk_out  out  NUM_CH  divided clock; toggles at each wrap.
- busy  out  NUM_CH  channel has a pending divisor not yet applied.

Behaviour:
- Reset (rst_n low, asynchronous): all counters = 0, active divisor = DEFAULT_DIV, shadow = 0, tick = 0, clk_out = 0, busy = 0. load_ready = 1 after reset, combinationally.
- Per channel, when en=1 and active div D >= 1:
  - The counter counts 0..D-1.
  - On the edge where count == D-1: count becomes 0, tick = 1 for that cycle (registered), and clk_out toggles.
  - clk_out period = 2*D clki cycles; tick period = D cycles.
- D == 1: tick is held high continuously, and clk_out toggles every cycle.
- D == 0: channel is stopped. Counter is held at 0, tick = 0, clk_out holds its value. It is not an error.
- en=0: counter cleared to 0, tick = 0, clk_out forced to 0 on the next edge. Re-enabling restarts counting from 0, and the first tick comes D cycles after en rises.
- Load handshake:
  - load_ready = ~busy[load_ch]; it is 0 if load_ch >= NUM_CH.
  - On acceptance: shadow[load_ch] = load_div and busy[load_ch] = 1.
  - An out-of-range load_ch is never accepted and has no effect.
- Apply rule: a pending shadow becomes active on the same edge the channel wraps. That edge still produces the tick and toggle, and counting under the new divisor starts from 0. busy clears on that edge.
- A pending shadow is applied immediately on the next edge, with no tick, if the channel is disabled or its current divisor is 0.
- Applying a new divisor never truncates a running period, so there is no clk_out pulse shorter than min(old,new) cycles.
- Simultaneous load on a channel that is wrapping in the same cycle: that channel's busy=0, so the load is accepted. The wrap uses the old active divisor, and the new shadow is pending until the following wrap.
- Channels are fully independent. A load on one channel never perturbs another channel's counter.
- Reset mid-operation discards pending shadows and restores DEFAULT_DIV on all channels.
- Counter compare uses an equality to D-1 computed at CNT_W bits. D = 2**CNT_W-1 is supported.

Test Plan:
- DEFAULT_DIV=5, NUM_CH=2, en=2'b11 after reset -> tick[0] high at cycles 5, 10, 15 after en; clk_out[0] rises at cycle 5, falls at 10, period 10.
- Load ch1 div=3 at cycle 2 (D=5 running) -> busy[1]=1 and load_ready low for ch1 until the wrap at cycle 5. Next ticks at 8, 11; ch0 is unaffected.
- Load div=1 on ch0 -> after apply, tick[0] is continuously high and clk_out[0] toggles every cycle. Then load div=0 -> tick stays 0 and clk_out freezes.
- Drop en[0] mid-count at count=3, raise it 4 cycles later -> clk_out[0]=0 while disabled; first tick exactly 5 cycles after en rises.
- load_valid with load_ch=3 when NUM_CH=2 -> load_ready=0, with no state change on any channel.
- Assert rst_n low asynchronously mid-period with a pending load -> outputs 0 immediately and busy=0. After release, ticks resume at DEFAULT_DIV spacing.

Source files
------------

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - NUM_CH independent programmable clock dividers with tick strobes.
// Divisors reload through a valid/ready port and switch over only at a counter wrap.
module clk_div_multi #(
  parameter int CNT_W       = 27,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int DEFAULT_DIV = 2500000
) (
  input  logic              clki,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_div,
  output logic              load_ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] busy
);

  localparam int CH_N = 2 ** CH_W;

  logic [CH_N-1:0] busy_pad;
  logic            ch_in_range;
  logic            load_fire;

  // Pad busy to the full index space so any load_ch value selects a defined bit.
  assign busy_pad    = CH_N'(busy);
  assign ch_in_range = ({1'b0, load_ch} < (CH_W+1)'(NUM_CH));
  assign load_ready  = ch_in_range && !busy_pad[load_ch];
  assign load_fire   = load_valid && load_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic             pend;
    logic             tick_q;
    logic             clk_q;
    logic             running;
    logic             wrap;
    logic             take;

    assign running = en[i] && (div != '0);
    assign wrap    = running && (cnt == div - CNT_W'(1));
    assign take    = load_fire && (load_ch == CH_W'(i));

    always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        div    <= CNT_W'(DEFAULT_DIV);
        shadow <= '0;
        pend   <= 1'b0;
        tick_q <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (!en[i]) begin
          cnt   <= '0;
          clk_q <= 1'b0;
        end else if (div == '0) begin
          cnt <= '0;
        end else if (wrap) begin
          cnt    <= '0;
          tick_q <= 1'b1;
          clk_q  <= ~clk_q;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end

        // Idle channels adopt the shadow at once; running ones wait for the wrap.
        if (pend && (wrap || !running)) begin
          div  <= shadow;
          pend <= 1'b0;
        end

        // take implies pend was clear, so it never collides with the apply above.
        if (take) begin
          shadow <= load_div;
          pend   <= 1'b1;
        end
      end
    end

    assign tick[i]    = tick_q;
    assign clk_out[i] = clk_q;
    assign busy[i]    = pend;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed vector bench for clk_div_multi (2 channels, divisor 5).
module tb_clk_div_multi;

  logic       clki;
  logic       rst_n;
  logic [1:0] en;
  logic       load_valid;
  logic [1:0] load_ch;
  logic [7:0] load_div;
  logic       load_ready;
  logic [1:0] tick;
  logic [1:0] clk_out;
  logic [1:0] busy;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(
    .CNT_W(8), .NUM_CH(2), .CH_W(2), .DEFAULT_DIV(5)
  ) dut (
    .clki(clki), .rst_n(rst_n), .en(en),
    .load_valid(load_valid), .load_ch(load_ch), .load_div(load_div),
    .load_ready(load_ready), .tick(tick), .clk_out(clk_out), .busy(busy)
  );

  initial clki = 1'b0;
  always #5 clki = ~clki;

  typedef struct {
    logic [1:0] en;
    logic       lv;
    logic [1:0] lch;
    logic [7:0] ldiv;
    logic       rdy;
    logic [1:0] tk;
    logic [1:0] ck;
    logic [1:0] bz;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic [1:0] e, input logic v, input logic [1:0] c,
                              input logic [7:0] d, input logic r, input logic [1:0] t,
                              input logic [1:0] k, input logic [1:0] b);
    vec_t x;
    x.en = e; x.lv = v; x.lch = c; x.ldiv = d; x.rdy = r; x.tk = t; x.ck = k; x.bz = b;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clki);
    #1;
  endtask

  initial begin
    int gap;
    int n;
    logic expc;

    // Row i describes the inputs before edge i+1 after en rises, and the outputs after it.
    vecs[0]  = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b00, 2'b00, 2'b00);
    vecs[1]  = mk(2'b11, 1'b1, 2'd1, 8'd3, 1'b1, 2'b00, 2'b00, 2'b10);
    vecs[2]  = mk(2'b11, 1'b1, 2'd1, 8'd7, 1'b0, 2'b00, 2'b00, 2'b10);
    vecs[3]  = mk(2'b11, 1'b1, 2'd3, 8'd2, 1'b0, 2'b00, 2'b00, 2'b10);
    vecs[4]  = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b11, 2'b11, 2'b00);
    vecs[5]  = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b00, 2'b11, 2'b00);
    vecs[6]  = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b00, 2'b11, 2'b00);
    vecs[7]  = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b10, 2'b01, 2'b00);
    vecs[8]  = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b00, 2'b01, 2'b00);
    vecs[9]  = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b01, 2'b00, 2'b00);
    vecs[10] = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b10, 2'b10, 2'b00);
    vecs[11] = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b00, 2'b10, 2'b00);
    vecs[12] = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b00, 2'b10, 2'b00);
    vecs[13] = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b10, 2'b00, 2'b00);
    vecs[14] = mk(2'b11, 1'b0, 2'd0, 8'd0, 1'b1, 2'b01, 2'b01, 2'b00);

    rst_n = 1'b0; en = 2'b00; load_valid = 1'b0; load_ch = 2'd0; load_div = 8'd0;
    #2;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_clk", 32'(clk_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(load_ready), 1);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      en = vecs[i].en; load_valid = vecs[i].lv; load_ch = vecs[i].lch; load_div = vecs[i].ldiv;
      #1;
      chk($sformatf("r%0d_ready", i), 32'(load_ready), 32'(vecs[i].rdy));
      cycle();
      chk($sformatf("r%0d_tick", i), 32'(tick), 32'(vecs[i].tk));
      chk($sformatf("r%0d_clk", i), 32'(clk_out), 32'(vecs[i].ck));
      chk($sformatf("r%0d_busy", i), 32'(busy), 32'(vecs[i].bz));
    end
    load_valid = 1'b0; load_ch = 2'd0;

    // Load on ch0 in the same cycle it wraps: wrap keeps old divisor, div=1 pends.
    repeat (4) cycle();
    load_valid = 1'b1; load_ch = 2'd0; load_div = 8'd1;
    #1 chk("wrapload_ready", 32'(load_ready), 1);
    cycle();
    load_valid = 1'b0;
    chk("wrapload_tick", 32'(tick[0]), 1);
    chk("wrapload_clk", 32'(clk_out[0]), 0);
    chk("wrapload_busy", 32'(busy[0]), 1);
    repeat (4) cycle();
    chk("pend_tick", 32'(tick[0]), 0);
    chk("pend_busy", 32'(busy[0]), 1);
    cycle();
    chk("apply1_tick", 32'(tick[0]), 1);
    chk("apply1_clk", 32'(clk_out[0]), 1);
    chk("apply1_busy", 32'(busy[0]), 0);
    expc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      expc = ~expc;
      chk($sformatf("div1_tick%0d", i), 32'(tick[0]), 1);
      chk($sformatf("div1_clk%0d", i), 32'(clk_out[0]), 32'(expc));
    end

    // Divisor 0 stops the channel with clk_out frozen.
    load_valid = 1'b1; load_div = 8'd0;
    #1 chk("div0_ready", 32'(load_ready), 1);
    cycle();
    load_valid = 1'b0;
    chk("div0_acc_tick", 32'(tick[0]), 1);
    chk("div0_acc_busy", 32'(busy[0]), 1);
    chk("div0_acc_clk", 32'(clk_out[0]), 0);
    cycle();
    chk("div0_app_tick", 32'(tick[0]), 1);
    chk("div0_app_clk", 32'(clk_out[0]), 1);
    chk("div0_app_busy", 32'(busy[0]), 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk($sformatf("stop_tick%0d", i), 32'(tick[0]), 0);
      chk($sformatf("stop_clk%0d", i), 32'(clk_out[0]), 1);
    end

    // Stopped channel takes a new divisor on the next edge with no tick.
    load_valid = 1'b1; load_div = 8'd5;
    #1;
    cycle();
    load_valid = 1'b0;
    chk("restart_acc_busy", 32'(busy[0]), 1);
    cycle();
    chk("restart_busy", 32'(busy[0]), 0);
    chk("restart_tick", 32'(tick[0]), 0);
    chk("restart_clk", 32'(clk_out[0]), 1);

    // Disable at count 3 for 4 cycles, then first tick 5 edges after re-enable.
    repeat (3) cycle();
    en = 2'b10;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("dis_clk%0d", i), 32'(clk_out[0]), 0);
      chk($sformatf("dis_tick%0d", i), 32'(tick[0]), 0);
    end
    en = 2'b11;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      chk($sformatf("reen_tick%0d", i), 32'(tick[0]), (i == 5) ? 1 : 0);
    end
    chk("reen_clk", 32'(clk_out[0]), 1);

    // Out-of-range channel is never ready and changes nothing.
    load_valid = 1'b1; load_ch = 2'd3; load_div = 8'd9;
    #1 chk("oor3_ready", 32'(load_ready), 0);
    load_ch = 2'd2;
    #1 chk("oor2_ready", 32'(load_ready), 0);
    cycle();
    load_valid = 1'b0; load_ch = 2'd0;
    chk("oor_busy", 32'(busy), 0);

    // Async reset with a pending load on ch1.
    load_valid = 1'b1; load_ch = 2'd1; load_div = 8'd7;
    #1 chk("prerst_ready", 32'(load_ready), 1);
    cycle();
    load_valid = 1'b0;
    chk("prerst_busy", 32'(busy), 2);
    chk("prerst_clk0", 32'(clk_out[0]), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 0);
    chk("arst_clk", 32'(clk_out), 0);
    chk("arst_busy", 32'(busy), 0);
    #20 rst_n = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      chk($sformatf("post_tick%0d", i), 32'(tick), (i % 5 == 0) ? 3 : 0);
      chk($sformatf("post_busy%0d", i), 32'(busy), 0);
    end

    // Largest divisor 2**CNT_W-1 on ch1.
    load_valid = 1'b1; load_ch = 2'd1; load_div = 8'd255;
    #1 chk("max_ready", 32'(load_ready), 1);
    cycle();
    load_valid = 1'b0;
    n = 0;
    while (busy[1] && n < 50) begin
      cycle();
      n++;
    end
    chk("max_apply_busy", 32'(busy[1]), 0);
    chk("max_apply_tick", 32'(tick[1]), 1);
    gap = 0;
    do begin
      cycle();
      gap++;
    end while (!tick[1] && gap < 600);
    chk("max_gap", gap, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
